// File: rtl/rx_byte_fifo.sv
// ---------------------------------------------------------------------------
// rx_byte_fifo
//
// Byte FIFO sitting behind a UART receiver. The receiver raises rx_ready as a
// level when a byte is complete and keeps it high until its next start bit,
// so one byte is pushed per rising edge of rx_ready. Bytes are popped by the
// consumer with rd_en. A byte arriving while the FIFO is full (and no pop
// frees a slot in the same cycle) is dropped and flagged in the sticky
// overflow bit, which is cleared with clr_ovf. A drop and a clear in the same
// cycle leave overflow set.
//
// Build option: RX_BYTE_FIFO_FWFT_EN
//   defined   : first-word fall-through; rd_data shows the head byte
//               combinationally, rd_valid = ~empty, rd_en pops that byte.
//   undefined : registered read; an accepted pop loads the head byte into
//               rd_data at the next edge and pulses rd_valid for one cycle.
//
// Parameters
//   DEPTH : number of byte entries (power of two, 4..256)
//   AW    : pointer width, must equal log2(DEPTH)
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   rx_ready in   byte-done level from the UART receiver
//   rx_data  in   received byte, valid while rx_ready is high
//   rd_en    in   consumer pop request
//   rd_data  out  byte presented to the consumer
//   rd_valid out  rd_data qualifier (meaning depends on build option)
//   empty    out  entry count is 0
//   full     out  entry count is DEPTH
//   level    out  entry count, 0..DEPTH
//   overflow out  sticky: a byte was dropped
//   clr_ovf  in   synchronous clear for overflow
// ---------------------------------------------------------------------------
module rx_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_ready,
    input  logic [7:0]    rx_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic          overflow,
    input  logic          clr_ovf
);

    generate
        if (AW != $clog2(DEPTH) || DEPTH < 4 || DEPTH > 256 || (1 << AW) != DEPTH) begin : g_param_check
            $error("rx_byte_fifo: DEPTH must be a power of two in 4..256 and AW = log2(DEPTH)");
        end
    endgenerate

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          ready_d;

    logic push;
    logic pop_ok;
    logic push_ok;
    logic drop;

    // ---- edge detect / accept decisions ----------------------------------
    // ready_d resets high so a receiver already signalling (or unknown) at
    // reset release cannot create a push; rx_ready must go low first.
    assign push    = rx_ready & ~ready_d;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = rd_en & ~empty;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok;
    assign level   = count;

    // ---- control state ----------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_d  <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            ready_d <= rx_ready;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + (AW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - (AW+1)'(1);
            end
            // Set has priority over clear so a drop is never lost.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // ---- storage (not reset) ---------------------------------------------
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // ---- read port --------------------------------------------------------
`ifdef RX_BYTE_FIFO_FWFT_EN
    // Head byte is forced to zero while empty so rd_data reads 0 in reset
    // and never exposes stale storage.
    assign rd_data  = empty ? 8'h00 : mem[rd_ptr];
    assign rd_valid = ~empty;
`else
    logic [7:0] rd_data_q;
    logic       rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= pop_ok;
            if (pop_ok) begin
                rd_data_q <= mem[rd_ptr];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_rx_byte_fifo.sv
// ---------------------------------------------------------------------------
// tb_rx_byte_fifo
//
// Directed bench for rx_byte_fifo (DEPTH=16). Inputs are driven and outputs
// sampled 1 ns after each rising clock edge. Expected values are hand-written
// constants. Prints one summary line: CHECKS <n> ERRORS <n>.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rx_byte_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       overflow;
    logic       clr_ovf;

    int checks = 0;
    int errors = 0;

    rx_byte_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .level    (level),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One rx_ready pulse carrying byte b; count is updated after the first edge.
    task automatic push_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
    endtask

    task automatic pop_byte(input logic [7:0] exp, input string tag);
`ifdef RX_BYTE_FIFO_FWFT_EN
        check({tag, "_vld"}, {31'd0, rd_valid}, 32'd1);
        check(tag, {24'd0, rd_data}, {24'd0, exp});
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
`else
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check({tag, "_vld"}, {31'd0, rd_valid}, 32'd1);
        check(tag, {24'd0, rd_data}, {24'd0, exp});
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        rd_en    = 1'b0;
        clr_ovf  = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_level", {27'd0, level}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_vld", {31'd0, rd_valid}, 32'd0);
        check("rst_data", {24'd0, rd_data}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // Pop on empty is ignored
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("empty_pop_level", {27'd0, level}, 32'd0);
        check("empty_pop_vld", {31'd0, rd_valid}, 32'd0);

        // Single byte, rx_ready held 40 cycles -> one push
        rx_data  = 8'h5A;
        rx_ready = 1'b1;
        tick();
        check("single_level_1st", {27'd0, level}, 32'd1);
        for (int i = 0; i < 39; i++) tick();
        check("single_level_40", {27'd0, level}, 32'd1);
        rx_ready = 1'b0;
        tick();
        check("single_empty", {31'd0, empty}, 32'd0);
        pop_byte(8'h5A, "single_data");
        tick();
`ifndef RX_BYTE_FIFO_FWFT_EN
        check("single_vld_pulse", {31'd0, rd_valid}, 32'd0);
        check("single_data_hold", {24'd0, rd_data}, 32'h5A);
`endif
        check("single_empty_after", {31'd0, empty}, 32'd1);

        // Fill and drop
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(i));
            if (i == 14) check("fill15_full", {31'd0, full}, 32'd0);
        end
        check("fill16_full", {31'd0, full}, 32'd1);
        check("fill16_level", {27'd0, level}, 32'd16);
        check("fill16_ovf", {31'd0, overflow}, 32'd0);
        rx_data  = 8'h10;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("drop_ovf", {31'd0, overflow}, 32'd1);
        check("drop_level", {27'd0, level}, 32'd16);
        tick();
        for (int i = 0; i < 16; i++) pop_byte(8'(i), "fill_read");
        tick();
        check("fill_read_empty", {31'd0, empty}, 32'd1);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_ovf", {31'd0, overflow}, 32'd0);

        // Push while empty with rd_en high: pop ignored
        rx_data  = 8'h33;
        rx_ready = 1'b1;
        rd_en    = 1'b1;
        tick();
        rx_ready = 1'b0;
        rd_en    = 1'b0;
        check("empty_pushpop_level", {27'd0, level}, 32'd1);
`ifndef RX_BYTE_FIFO_FWFT_EN
        check("empty_pushpop_vld", {31'd0, rd_valid}, 32'd0);
`endif
        tick();
        pop_byte(8'h33, "empty_pushpop_data");

        // Simultaneous push and pop at full
        for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
        check("sim_full", {31'd0, full}, 32'd1);
`ifdef RX_BYTE_FIFO_FWFT_EN
        check("sim_head", {24'd0, rd_data}, 32'h20);
`endif
        rx_data  = 8'hAA;
        rx_ready = 1'b1;
        rd_en    = 1'b1;
        tick();
        rx_ready = 1'b0;
        rd_en    = 1'b0;
        check("sim_level", {27'd0, level}, 32'd16);
        check("sim_ovf", {31'd0, overflow}, 32'd0);
`ifndef RX_BYTE_FIFO_FWFT_EN
        check("sim_pop_data", {24'd0, rd_data}, 32'h20);
`endif
        tick();
        for (int i = 1; i < 16; i++) pop_byte(8'h20 + 8'(i), "sim_read");
        pop_byte(8'hAA, "sim_read_last");
        tick();
        check("sim_empty", {31'd0, empty}, 32'd1);

        // Clear vs drop priority
        for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
        push_byte(8'h99);
        check("cd_ovf_set", {31'd0, overflow}, 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("cd_clr", {31'd0, overflow}, 32'd0);
        rx_data  = 8'h98;
        rx_ready = 1'b1;
        clr_ovf  = 1'b1;
        tick();
        rx_ready = 1'b0;
        clr_ovf  = 1'b0;
        check("cd_set_wins", {31'd0, overflow}, 32'd1);
        check("cd_level", {27'd0, level}, 32'd16);
        tick();

        // Reset mid-operation at level 7, rx_ready held through release
        for (int i = 0; i < 9; i++) pop_byte(8'h40 + 8'(i), "pre_rst_read");
        tick();
        check("pre_rst_level", {27'd0, level}, 32'd7);
        rx_data  = 8'h77;
        rx_ready = 1'b1;
        rst_n    = 1'b0;
        #1;
        check("mid_rst_level", {27'd0, level}, 32'd0);
        check("mid_rst_empty", {31'd0, empty}, 32'd1);
        check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        check("mid_rst_vld", {31'd0, rd_valid}, 32'd0);
        check("mid_rst_data", {24'd0, rd_data}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("rel_high_no_push", {27'd0, level}, 32'd0);
        rx_ready = 1'b0;
        tick();
        check("rel_low_no_push", {27'd0, level}, 32'd0);
        rx_ready = 1'b1;
        tick();
        check("rel_toggle_push", {27'd0, level}, 32'd1);
        rx_ready = 1'b0;
        tick();
        pop_byte(8'h77, "rel_data");

        // Wrap: interleaved push/pop pairs
        for (int i = 0; i < 40; i++) begin
            push_byte(8'h80 + 8'(i));
            check("wrap_level", {27'd0, level}, 32'd1);
            pop_byte(8'h80 + 8'(i), "wrap_data");
        end
        tick();
        check("wrap_empty", {31'd0, empty}, 32'd1);
        check("wrap_ovf", {31'd0, overflow}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
